// File: rtl/dec_1x2_u_2x1_mux_pkg.sv
// Shared constants for the 1-to-2 line decoder.
// Optional statistics are enabled with DEC_STATS_EN.
package dec_1x2_pkg;

    localparam logic [1:0] DEC_Y0   = 2'b01;
    localparam logic [1:0] DEC_Y1   = 2'b10;
    localparam logic [1:0] DEC_IDLE = 2'b00;

    localparam int DEC_CNT_W = 16;

endpackage

// File: rtl/dec_1x2_u_2x1_mux_if.sv
// Decoder bus: select in, one-hot decode out.
// Counter lines exist only when DEC_STATS_EN is defined.
interface dec_1x2_u_2x1_mux_if
    import dec_1x2_pkg::*;
#(
    parameter int CNT_W = DEC_CNT_W
);

    logic             i;
    logic [1:0]       y;
    logic [1:0]       y_q;
`ifdef DEC_STATS_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output i,
        input  y, y_q, cnt0, cnt1
    );

    modport slave (
        input  i,
        output y, y_q, cnt0, cnt1
    );
`else
    modport master (
        output i,
        input  y, y_q
    );

    modport slave (
        input  i,
        output y, y_q
    );
`endif

endinterface

// File: rtl/dec_1x2_u_2x1_mux_mux2_1.sv
// 2:1 multiplexer primitive; one instance per decode line.
// Purely combinational.
module mux2_1 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/dec_1x2_u_2x1_mux.sv
// 1-to-2 decoder from two mux2_1 cells, registered copy and
// optional saturating line counters (DEC_STATS_EN).
module dec_1x2_u_2x1_mux
    import dec_1x2_pkg::*;
#(
    parameter int CNT_W = DEC_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    dec_1x2_u_2x1_mux_if.slave    bus
);

    logic       y0;
    logic       y1;
    logic [1:0] y_q;

    mux2_1 u_mux_y0 (
        .d0  (1'b1),
        .d1  (1'b0),
        .sel (bus.i),
        .y   (y0)
    );

    mux2_1 u_mux_y1 (
        .d0  (1'b0),
        .d1  (1'b1),
        .sel (bus.i),
        .y   (y1)
    );

    assign bus.y = {y1, y0};

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= DEC_IDLE;
        end else begin
            y_q <= {y1, y0};
        end
    end

    assign bus.y_q = y_q;

`ifdef DEC_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Counters look at y_q before the edge, so they trail it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (y_q == DEC_Y0 && cnt0_q != CNT_MAX) begin
                cnt0_q <= cnt0_q + CNT_ONE;
            end
            if (y_q == DEC_Y1 && cnt1_q != CNT_MAX) begin
                cnt1_q <= cnt1_q + CNT_ONE;
            end
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_dec_1x2_u_2x1_mux.sv
// Self-checking bench for dec_1x2_u_2x1_mux (counter checks need DEC_STATS_EN).
// Counters run at width 4 so saturation is reachable quickly.
module tb_dec_1x2_u_2x1_mux;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dec_1x2_u_2x1_mux_if #(.CNT_W(CW)) bus ();

    dec_1x2_u_2x1_mux #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: last registered decode and line hit counts.
    logic [1:0] m_yq = 2'b00;
    int         m_c0 = 0;
    int         m_c1 = 0;

    typedef struct {
        logic       rst;
        logic       i;
        logic [1:0] y;
        logic [1:0] yq;
        int         c0;
        int         c1;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] act,
                          input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [1:0] decode(input logic sel);
        return (sel == 1'b1) ? 2'b10 : 2'b01;
    endfunction

    // Model one rising edge from the decode rules.
    task automatic model_edge(input logic r, input logic iv);
        if (r) begin
            m_yq = 2'b00;
            m_c0 = 0;
            m_c1 = 0;
        end else begin
            if (m_yq == 2'b01) m_c0 = (m_c0 + 1 > SAT) ? SAT : m_c0 + 1;
            if (m_yq == 2'b10) m_c1 = (m_c1 + 1 > SAT) ? SAT : m_c1 + 1;
            m_yq = decode(iv);
        end
    endtask

    // Drive inputs at the falling edge, clock once, sample at the next fall.
    task automatic step(input logic r, input logic iv);
        rst   = r;
        bus.i = iv;
        @(posedge clk);
        model_edge(r, iv);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check2({tag, ".y"},  bus.y,   decode(bus.i));
        check2({tag, ".yq"}, bus.y_q, m_yq);
`ifdef DEC_STATS_EN
        check({tag, ".cnt0"}, int'(bus.cnt0), m_c0);
        check({tag, ".cnt1"}, int'(bus.cnt1), m_c1);
`endif
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 2'b10, 2'b00, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 2'b00, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 2'b01, 2'b01, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 2'b10, 2'b10, 1, 0};
        vecs[4] = '{1'b0, 1'b0, 2'b01, 2'b01, 1, 1};
        vecs[5] = '{1'b0, 1'b1, 2'b10, 2'b10, 2, 1};

        bus.i = 1'b1;
        @(negedge clk);

        // Reset, decode latency and toggling from the vector table.
        for (int k = 0; k < 6; k++) begin
            step(vecs[k].rst, vecs[k].i);
            check2($sformatf("vec%0d.y", k),  bus.y,   vecs[k].y);
            check2($sformatf("vec%0d.yq", k), bus.y_q, vecs[k].yq);
`ifdef DEC_STATS_EN
            check($sformatf("vec%0d.cnt0", k), int'(bus.cnt0), vecs[k].c0);
            check($sformatf("vec%0d.cnt1", k), int'(bus.cnt1), vecs[k].c1);
`endif
        end

        // Combinational path settles without a clock edge.
        @(posedge clk);
        #1 bus.i = 1'b0;
        #10 check2("comb.i0", bus.y, 2'b01);
        bus.i = 1'b1;
        #10 check2("comb.i1", bus.y, 2'b10);
        @(negedge clk);

        // y follows i while held in reset.
        rst   = 1'b1;
        bus.i = 1'b0;
        #1 check2("comb.in_rst", bus.y, 2'b01);
        @(negedge clk);

        // Statistics: 5 cycles of i=0 then 3 of i=1.
        step(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        check2("stats.yq", bus.y_q, 2'b10);
`ifdef DEC_STATS_EN
        check("stats.cnt0", int'(bus.cnt0), 5);
        check("stats.cnt1", int'(bus.cnt1), 2);
`endif

        // Saturation: 20 cycles of i=1 on 4-bit counters.
        step(1'b1, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1);
`ifdef DEC_STATS_EN
        check("sat.cnt1", int'(bus.cnt1), 15);
        check("sat.cnt0", int'(bus.cnt0), 0);
`endif

        // Mid-run reset pulse then counting resumes from zero.
        step(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
`ifdef DEC_STATS_EN
        check("mid.pre.cnt1", int'(bus.cnt1), 2);
`endif
        step(1'b1, 1'b1);
        check2("mid.rst.yq", bus.y_q, 2'b00);
        check2("mid.rst.y", bus.y, 2'b10);
`ifdef DEC_STATS_EN
        check("mid.rst.cnt1", int'(bus.cnt1), 0);
`endif
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check2("mid.post.yq", bus.y_q, 2'b10);
`ifdef DEC_STATS_EN
        check("mid.post.cnt1", int'(bus.cnt1), 1);
        check("mid.post.cnt0", int'(bus.cnt0), 0);
`endif

        // Random stimulus against the reference model.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            check_model($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
